// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the rv32 memory-access stage: access widths,
// branch operations and the bus-transfer FSM state.
package rv32_mem_pkg;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'b10;

  localparam logic [1:0] BRANCH_OP_NEVER    = 2'b00;
  localparam logic [1:0] BRANCH_OP_ZERO     = 2'b01;
  localparam logic [1:0] BRANCH_OP_NON_ZERO = 2'b10;
  localparam logic [1:0] BRANCH_OP_ALWAYS   = 2'b11;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_WAIT = 1'b1
  } mem_state_t;

  // Branch decision from the ALU result (comparison already folded into result).
  function automatic logic branch_cond(input logic [1:0] op, input logic [31:0] result);
    case (op)
      BRANCH_OP_ZERO:     branch_cond = (result == 32'd0);
      BRANCH_OP_NON_ZERO: branch_cond = (result != 32'd0);
      BRANCH_OP_ALWAYS:   branch_cond = 1'b1;
      default:            branch_cond = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_mem_align.sv
// Byte-lane logic: store strobes and shifting, load extraction and
// extension, and misalignment detection. Purely combinational.
module rv32_mem_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  width,
  input  logic        zero_extend,
  input  logic [1:0]  offset,
  input  logic [31:0] store_value,
  input  logic [31:0] load_raw,
  output logic [3:0]  write_mask,
  output logic [31:0] write_value,
  output logic [31:0] load_value,
  output logic        misaligned
);

  logic [4:0]  shamt;
  logic [31:0] load_shifted;

  assign shamt = {offset, 3'b000};

  // Lane placement for stores and lane extraction for loads; reserved width acts as word.
  always_comb begin
    write_mask   = 4'b1111;
    misaligned   = 1'b0;
    write_value  = store_value << shamt;
    load_shifted = load_raw >> shamt;
    load_value   = load_shifted;
    case (width)
      MEM_WIDTH_BYTE: begin
        write_mask = 4'b0001 << offset;
        load_value = zero_extend ? {24'd0, load_shifted[7:0]}
                                 : {{24{load_shifted[7]}}, load_shifted[7:0]};
      end
      MEM_WIDTH_HALF: begin
        write_mask = 4'b0011 << offset;
        misaligned = offset[0];
        load_value = zero_extend ? {16'd0, load_shifted[15:0]}
                                 : {{16{load_shifted[15]}}, load_shifted[15:0]};
      end
      default: begin
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/rv32_mem.sv
// rv32 memory-access pipeline stage: issues bus requests for loads and
// stores, stalls upstream while a transfer is outstanding, resolves the
// branch and registers the result for writeback.
//
// Bus handshake: data_read_out / data_write_out act as "valid" and are held
// stable (upstream is stalled) until the cycle data_ready_in is 1; that cycle
// the transfer completes, read data is sampled, and the stage retires.
module rv32_mem
  import rv32_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic [1:0]  branch_op_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_writeback_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [31:0] branch_pc_in,
  output logic [29:0] data_address_out,
  output logic        data_read_out,
  output logic        data_write_out,
  output logic [3:0]  data_write_mask_out,
  output logic [31:0] data_write_value_out,
  input  logic [31:0] data_read_value_in,
  input  logic        data_ready_in,
  output logic        stall_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_pc_out,
  output logic        misaligned_out,
  output logic [4:0]  rd_out,
  output logic        rd_writeback_out,
  output logic [31:0] rd_value_out,
  output logic        state_debug
);

  mem_state_t  state, state_next;
  logic        misaligned;
  logic        mem_op;
  logic        mem_misaligned;
  logic        access;
  logic        is_load;
  logic [31:0] load_value;

  rv32_mem_align u_align (
    .width       (mem_width_in),
    .zero_extend (mem_zero_extend_in),
    .offset      (result_in[1:0]),
    .store_value (rs2_value_in),
    .load_raw    (data_read_value_in),
    .write_mask  (data_write_mask_out),
    .write_value (data_write_value_out),
    .load_value  (load_value),
    .misaligned  (misaligned)
  );

  assign mem_op         = valid_in & (mem_read_en_in | mem_write_en_in);
  assign mem_misaligned = mem_op & misaligned;
  assign access         = mem_op & ~misaligned;
  // Read and write together is treated as a write.
  assign is_load        = access & mem_read_en_in & ~mem_write_en_in;

  // Requests drop immediately under reset so an aborted transfer is not seen.
  assign data_address_out = result_in[31:2];
  assign data_read_out    = reset_n & is_load;
  assign data_write_out   = reset_n & access & mem_write_en_in;
  assign stall_out        = reset_n & access & ~data_ready_in;
  assign state_debug      = state;

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= STATE_IDLE;
    else          state <= state_next;
  end

  // Next state: park in WAIT while a request is outstanding.
  always_comb begin
    state_next = state;
    case (state)
      STATE_IDLE: if (access && !data_ready_in) state_next = STATE_WAIT;
      STATE_WAIT: if (data_ready_in || !access) state_next = STATE_IDLE;
      default:    state_next = STATE_IDLE;
    endcase
  end

  // Writeback registers: retire when not stalled, otherwise present a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_out           <= 5'd0;
      rd_writeback_out <= 1'b0;
      rd_value_out     <= 32'd0;
      branch_taken_out <= 1'b0;
      branch_pc_out    <= 32'd0;
      misaligned_out   <= 1'b0;
    end else if (stall_out) begin
      rd_writeback_out <= 1'b0;
      branch_taken_out <= 1'b0;
      misaligned_out   <= 1'b0;
    end else begin
      rd_out           <= rd_in;
      rd_writeback_out <= valid_in & ~mem_misaligned & rd_writeback_in;
      rd_value_out     <= is_load ? load_value : result_in;
      branch_taken_out <= valid_in & ~mem_misaligned & branch_cond(branch_op_in, result_in);
      branch_pc_out    <= branch_pc_in;
      misaligned_out   <= mem_misaligned;
    end
  end

endmodule
